// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - state encodings and oversample helpers for uart_param_core (UART_PARITY_EN adds parity states)
package uart_pkg;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

  // Width of a counter that walks the oversample ticks of one bit
  function automatic int os_cnt_w(input int oversample);
    return $clog2(oversample);
  endfunction

  // Tick index (1-based) at which the middle of a bit is reached
  function automatic int mid_tick(input int oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running oversample tick generator, one tick every max(baud_div,1) clk
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  output logic        tick
);

  logic [15:0] cnt;

  assign tick = (cnt == 16'd0);

  // Down-counter reloads from the live divisor, so a new baud_div applies at the next reload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (tick) begin
      cnt <= (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/uart_param_core.sv
// rtl/uart_param_core.sv - parametrised full-duplex UART with RX FIFO; UART_PARITY_EN adds parity bit and parity_err
module uart_param_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   baud_div,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  input  logic                          rx,
  output logic                          tx,
  output logic                          frame_err,
  output logic                          rx_overrun
`ifdef UART_PARITY_EN
  , output logic                        parity_err
`endif
);

  localparam int OSW = os_cnt_w(OVERSAMPLE);
  localparam int DBW = $clog2(DATA_BITS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] MID_LAST = OSW'(mid_tick(OVERSAMPLE) - 1);
  localparam logic [DBW-1:0] BIT_LAST = DBW'(DATA_BITS - 1);

  logic tick;

  uart_baud_gen u_baud (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .tick     (tick)
  );

  tx_state_t            tx_state;
  logic                 tx_run;
  logic [OSW-1:0]       tx_os;
  logic [DBW-1:0]       tx_idx;
  logic                 tx_stop;
  logic [DATA_BITS-1:0] tx_shift;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  // TX: latch on accept, first tick opens the start bit, each bit lasts OVERSAMPLE ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_run   <= 1'b0;
      tx_os    <= '0;
      tx_idx   <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_state == TX_IDLE) begin
      if (tx_valid) begin
        tx_shift <= tx_data;
        tx_ready <= 1'b0;
        tx_run   <= 1'b0;
        tx_state <= TX_START;
`ifdef UART_PARITY_EN
        tx_par   <= (^tx_data) ^ PARITY_ODD;
`endif
      end
    end else if (tick) begin
      if (!tx_run) begin
        tx_run <= 1'b1;
        tx     <= 1'b0;
        tx_os  <= '0;
      end else if (tx_os != OS_LAST) begin
        tx_os <= tx_os + 1'b1;
      end else begin
        tx_os <= '0;
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx       <= tx_shift[0];
            tx_idx   <= '0;
          end
          TX_DATA: begin
            if (tx_idx == BIT_LAST) begin
`ifdef UART_PARITY_EN
              tx_state <= TX_PARITY;
              tx       <= tx_par;
`else
              tx_state <= TX_STOP;
              tx       <= 1'b1;
              tx_stop  <= 1'b0;
`endif
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx_shift <= tx_shift >> 1;
              tx       <= tx_shift[1];
            end
          end
`ifdef UART_PARITY_EN
          TX_PARITY: begin
            tx_state <= TX_STOP;
            tx       <= 1'b1;
            tx_stop  <= 1'b0;
          end
`endif
          TX_STOP: begin
            if (tx_stop == 1'(STOP_BITS - 1)) begin
              tx_state <= TX_IDLE;
              tx_ready <= 1'b1;
              tx_run   <= 1'b0;
            end else begin
              tx_stop <= 1'b1;
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  rx_state_t            rx_state;
  logic                 rx_meta, rx_s, rx_prev;
  logic [OSW-1:0]       rx_os;
  logic [DBW-1:0]       rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_bit_end, stop_hit, push;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad;
`endif

  // Start bit is sampled half a bit after the edge, later bits a full bit apart
  always_comb begin
    rx_bit_end = tick && (rx_os == ((rx_state == RX_START) ? MID_LAST : OS_LAST));
    stop_hit   = rx_bit_end && (rx_state == RX_STOP);
    push       = stop_hit && rx_s;
  end

  // RX: synchronise the pin, walk the frame, flag stop/parity errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_os     <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      frame_err <= stop_hit && !rx_s;
`ifdef UART_PARITY_EN
      parity_err <= push && rx_par_bad;
`endif
      if (rx_state == RX_IDLE) begin
        // Only a falling edge arms RX, so a low line after a bad stop bit is ignored
        if (rx_prev && !rx_s) begin
          rx_state <= RX_START;
          rx_os    <= '0;
        end
      end else if (tick) begin
        if (!rx_bit_end) begin
          rx_os <= rx_os + 1'b1;
        end else begin
          rx_os <= '0;
          case (rx_state)
            RX_START: begin
              rx_state <= rx_s ? RX_IDLE : RX_DATA;
              rx_idx   <= '0;
            end
            RX_DATA: begin
              rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
              if (rx_idx == BIT_LAST) begin
`ifdef UART_PARITY_EN
                rx_state <= RX_PARITY;
`else
                rx_state <= RX_STOP;
`endif
              end else begin
                rx_idx <= rx_idx + 1'b1;
              end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
              rx_par_bad <= rx_s != ((^rx_shift) ^ PARITY_ODD);
              rx_state   <= RX_STOP;
            end
`endif
            default: rx_state <= RX_IDLE;
          endcase
        end
      end
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic                 do_pop, do_push, full;

  // A pop frees a slot in the same cycle, so push into a full FIFO with a pop is not an overrun
  always_comb begin
    do_pop  = rx_ready && (rx_count != '0);
    full    = (rx_count == CW'(FIFO_DEPTH));
    do_push = push && (!full || do_pop);
  end

  assign rx_valid = (rx_count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  // FIFO storage has no reset; empty entries are never presented
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_shift;
  end

  // FIFO pointers, occupancy and overrun pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= push && full && !do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      rx_count <= rx_count + 1'b1;
      else if (!do_push && do_pop) rx_count <= rx_count - 1'b1;
    end
  end

endmodule
